// File: rtl/pe_array_sched_pkg.sv
// Shared definitions for the PE array layer scheduler.
// State encoding and default geometry shared with the array top.
package pe_array_sched_pkg;

  localparam int CH_W_DEF      = 8;
  localparam int POS_W_DEF     = 10;
  localparam int ARRAY_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_WAIT_W,
    ST_STREAM,
    ST_DRAIN,
    ST_READOUT,
    ST_FINISH
  } state_e;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_array_sched_pipe.sv
// Valid/address delay line matching the PE array latency.
// Bubbles shift through as {0, 0} so write strobes stay aligned to beats.
module pe_valid_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 10
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         vld_in,
  input  logic [W-1:0] addr_in,
  output logic         vld_out,
  output logic [W-1:0] addr_out
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     addr_q [DEPTH];

  // Shift one stage per cycle, cleared asynchronously by reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= vld_in;
      addr_q[0] <= addr_in;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign vld_out  = vld_q[DEPTH-1];
  assign addr_out = addr_q[DEPTH-1];

endmodule

// File: rtl/pe_array_sched.sv
// Layer scheduler: weight load, activation stream, psum routing
// through the accumulator buffer, and final per-position readout.
module pe_array_sched
  import pe_array_sched_pkg::*;
#(
  parameter int CH_W      = CH_W_DEF,
  parameter int POS_W     = POS_W_DEF,
  parameter int ARRAY_LAT = ARRAY_LAT_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [CH_W-1:0]  num_ich_in,
  input  logic [POS_W-1:0] num_pos_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             wgt_rd_en_out,
  output logic [CH_W-1:0]  wgt_rd_addr_out,
  output logic             wgt_load_out,
  input  logic             act_valid_in,
  output logic             act_ready_out,
  output logic             act_load_out,
  output logic             psum_sel_out,
  output logic             acc_rd_en_out,
  output logic [POS_W-1:0] acc_rd_addr_out,
  output logic             acc_wr_en_out,
  output logic [POS_W-1:0] acc_wr_addr_out,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [POS_W-1:0] out_pos_out,
  output logic             out_last_out
);

  localparam int DW = cnt_w(ARRAY_LAT);
  localparam logic [DW-1:0] DLAST = DW'(ARRAY_LAT - 1);

  state_e           state_q;
  logic [CH_W-1:0]  num_ich_q;
  logic [POS_W-1:0] num_pos_q;
  logic [CH_W-1:0]  ch_q;
  logic [POS_W-1:0] pos_q;
  logic [DW-1:0]    dcnt_q;

  logic             beat;
  logic             pos_end;
  logic             ch_end;
  logic [POS_W-1:0] pos_nxt;
  logic [POS_W-1:0] push_addr;

  assign pos_nxt = pos_q + POS_W'(1);
  assign pos_end = (pos_nxt == num_pos_q);
  assign ch_end  = ((ch_q + CH_W'(1)) == num_ich_q);
  assign beat    = (state_q == ST_STREAM) & act_valid_in;

  assign push_addr = beat ? pos_q : '0;

  // Layer sequencing: state, latched counts and pass/position counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      num_ich_q <= '0;
      num_pos_q <= '0;
      ch_q      <= '0;
      pos_q     <= '0;
      dcnt_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            num_ich_q <= num_ich_in;
            num_pos_q <= num_pos_in;
            ch_q      <= '0;
            pos_q     <= '0;
            if (num_ich_in == '0 || num_pos_in == '0) begin
              state_q <= ST_FINISH;
            end else begin
              state_q <= ST_LOAD_W;
            end
          end
        end
        ST_LOAD_W: state_q <= ST_WAIT_W;
        ST_WAIT_W: state_q <= ST_STREAM;
        ST_STREAM: begin
          if (act_valid_in) begin
            pos_q <= pos_nxt;
            if (pos_end) begin
              dcnt_q  <= '0;
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (dcnt_q == DLAST) begin
            pos_q <= '0;
            if (ch_end) begin
              state_q <= ST_READOUT;
            end else begin
              ch_q    <= ch_q + CH_W'(1);
              state_q <= ST_LOAD_W;
            end
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        ST_READOUT: begin
          if (out_ready_in) begin
            pos_q <= pos_nxt;
            if (pos_end) begin
              state_q <= ST_FINISH;
            end
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobe decode from state, counters and the activation handshake.
  always_comb begin
    busy_out        = (state_q != ST_IDLE);
    done_out        = 1'b0;
    wgt_rd_en_out   = 1'b0;
    wgt_rd_addr_out = '0;
    wgt_load_out    = 1'b0;
    act_ready_out   = 1'b0;
    psum_sel_out    = 1'b0;
    acc_rd_en_out   = 1'b0;
    acc_rd_addr_out = '0;
    out_valid_out   = 1'b0;
    out_pos_out     = '0;
    out_last_out    = 1'b0;
    unique case (state_q)
      ST_LOAD_W: begin
        wgt_rd_en_out   = 1'b1;
        wgt_rd_addr_out = ch_q;
      end
      ST_WAIT_W: wgt_load_out = 1'b1;
      ST_STREAM: begin
        act_ready_out = 1'b1;
        if (act_valid_in) begin
          acc_rd_en_out   = 1'b1;
          acc_rd_addr_out = pos_q;
          psum_sel_out    = (ch_q != '0);
        end
      end
      ST_READOUT: begin
        out_valid_out   = 1'b1;
        out_pos_out     = pos_q;
        out_last_out    = pos_end;
        acc_rd_en_out   = 1'b1;
        acc_rd_addr_out = pos_q;
      end
      ST_FINISH: done_out = 1'b1;
      default: ;
    endcase
  end

  assign act_load_out = beat;

  pe_valid_pipe #(
    .DEPTH (ARRAY_LAT),
    .W     (POS_W)
  ) u_pipe (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .vld_in   (beat),
    .addr_in  (push_addr),
    .vld_out  (acc_wr_en_out),
    .addr_out (acc_wr_addr_out)
  );

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed bench for pe_array_sched: cycle table for a two-pass
// layer plus hand sequences for bubbles, stalls, reset and zero counts.
module tb_pe_array_sched;

  localparam int CH_W  = 8;
  localparam int POS_W = 10;
  localparam int LAT   = 2;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             start_in;
  logic [CH_W-1:0]  num_ich_in;
  logic [POS_W-1:0] num_pos_in;
  logic             busy_out, done_out;
  logic             wgt_rd_en_out, wgt_load_out;
  logic [CH_W-1:0]  wgt_rd_addr_out;
  logic             act_valid_in, act_ready_out, act_load_out;
  logic             psum_sel_out, acc_rd_en_out, acc_wr_en_out;
  logic [POS_W-1:0] acc_rd_addr_out, acc_wr_addr_out;
  logic             out_valid_out, out_ready_in, out_last_out;
  logic [POS_W-1:0] out_pos_out;

  always #5 clk_in = ~clk_in;

  pe_array_sched #(
    .CH_W(CH_W), .POS_W(POS_W), .ARRAY_LAT(LAT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .num_ich_in(num_ich_in), .num_pos_in(num_pos_in),
    .busy_out(busy_out), .done_out(done_out),
    .wgt_rd_en_out(wgt_rd_en_out),
    .wgt_rd_addr_out(wgt_rd_addr_out),
    .wgt_load_out(wgt_load_out),
    .act_valid_in(act_valid_in), .act_ready_out(act_ready_out),
    .act_load_out(act_load_out), .psum_sel_out(psum_sel_out),
    .acc_rd_en_out(acc_rd_en_out),
    .acc_rd_addr_out(acc_rd_addr_out),
    .acc_wr_en_out(acc_wr_en_out),
    .acc_wr_addr_out(acc_wr_addr_out),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .out_pos_out(out_pos_out), .out_last_out(out_last_out)
  );

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             wrd;
    logic [CH_W-1:0]  wra;
    logic             wld;
    logic             ardy;
    logic             ald;
    logic             psel;
    logic             ard;
    logic [POS_W-1:0] ara;
    logic             awe;
    logic [POS_W-1:0] awa;
    logic             ov;
    logic [POS_W-1:0] op;
    logic             ol;
  } obs_t;

  typedef struct {
    logic st;
    obs_t exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int wr_cyc[$], wr_adr[$], rd_cyc[$], rd_pos[$];
  int done_cyc, busy_n, strobe_n, stall_vld_n, last_ardy;

  function automatic obs_t mk(
    int b, int d, int wr, int wa, int wl, int ry, int ld,
    int ps, int ar, int ra, int we, int wwa, int ov, int op, int ol);
    obs_t o;
    o.busy = b[0]; o.done = d[0]; o.wrd = wr[0];
    o.wra = CH_W'(wa); o.wld = wl[0]; o.ardy = ry[0];
    o.ald = ld[0]; o.psel = ps[0]; o.ard = ar[0];
    o.ara = POS_W'(ra); o.awe = we[0]; o.awa = POS_W'(wwa);
    o.ov = ov[0]; o.op = POS_W'(op); o.ol = ol[0];
    return o;
  endfunction

  function automatic obs_t snap();
    obs_t o;
    o.busy = busy_out; o.done = done_out;
    o.wrd = wgt_rd_en_out; o.wra = wgt_rd_addr_out;
    o.wld = wgt_load_out; o.ardy = act_ready_out;
    o.ald = act_load_out; o.psel = psum_sel_out;
    o.ard = acc_rd_en_out; o.ara = acc_rd_addr_out;
    o.awe = acc_wr_en_out; o.awa = acc_wr_addr_out;
    o.ov = out_valid_out; o.op = out_pos_out;
    o.ol = out_last_out;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one layer from cycle 0 (start) until done_out, logging events.
  // Caller must be positioned 1 time unit after a rising edge.
  task automatic run_layer(input int ich, input int npos,
                           input bit alt_valid, input int stall_len,
                           input int busy_start);
    int stalled;
    int cyc;
    bit got_done;
    stalled = 0;
    got_done = 0;
    wr_cyc.delete(); wr_adr.delete();
    rd_cyc.delete(); rd_pos.delete();
    done_cyc = -1; busy_n = 0; strobe_n = 0;
    stall_vld_n = 0; last_ardy = -1;
    for (cyc = 0; cyc < 300 && !got_done; cyc++) begin
      start_in = (cyc == 0) || (cyc == busy_start);
      num_ich_in = (cyc == 0) ? CH_W'(ich) : CH_W'(5);
      num_pos_in = (cyc == 0) ? POS_W'(npos) : POS_W'(7);
      act_valid_in = alt_valid ? cyc[0] : 1'b1;
      if (out_valid_out && out_pos_out == POS_W'(1) &&
          stalled < stall_len) begin
        out_ready_in = 1'b0;
        stalled++;
      end else begin
        out_ready_in = 1'b1;
      end
      #1;
      if (busy_out) busy_n++;
      if (wgt_rd_en_out || wgt_load_out || acc_rd_en_out ||
          acc_wr_en_out || out_valid_out || act_load_out)
        strobe_n++;
      if (act_ready_out) last_ardy = cyc;
      if (acc_wr_en_out) begin
        wr_cyc.push_back(cyc);
        wr_adr.push_back(int'(acc_wr_addr_out));
      end
      if (out_valid_out && out_pos_out == POS_W'(1))
        stall_vld_n++;
      if (out_valid_out && out_ready_in) begin
        rd_cyc.push_back(cyc);
        rd_pos.push_back(int'(out_pos_out));
      end
      if (done_out) begin
        done_cyc = cyc;
        got_done = 1;
      end
      @(posedge clk_in); #1;
    end
    start_in = 1'b0;
    if (!got_done) chk("layer_timeout", 0, 1);
  endtask

  vec_t tv[20];
  int   rst_done_n;
  int   exp_wc[$], exp_wa[$];

  initial begin
    rst_in = 1'b1; start_in = 1'b0;
    num_ich_in = '0; num_pos_in = '0;
    act_valid_in = 1'b0; out_ready_in = 1'b0;

    // b d wr wa wl ry ld ps ar ra we wa ov op ol
    tv[0]  = '{1'b1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0)};
    tv[1]  = '{1'b0, mk(1,0,1,0,0,0,0,0,0,0,0,0,0,0,0)};
    tv[2]  = '{1'b0, mk(1,0,0,0,1,0,0,0,0,0,0,0,0,0,0)};
    tv[3]  = '{1'b0, mk(1,0,0,0,0,1,1,0,1,0,0,0,0,0,0)};
    tv[4]  = '{1'b0, mk(1,0,0,0,0,1,1,0,1,1,0,0,0,0,0)};
    tv[5]  = '{1'b0, mk(1,0,0,0,0,1,1,0,1,2,1,0,0,0,0)};
    tv[6]  = '{1'b0, mk(1,0,0,0,0,0,0,0,0,0,1,1,0,0,0)};
    tv[7]  = '{1'b0, mk(1,0,0,0,0,0,0,0,0,0,1,2,0,0,0)};
    tv[8]  = '{1'b0, mk(1,0,1,1,0,0,0,0,0,0,0,0,0,0,0)};
    tv[9]  = '{1'b0, mk(1,0,0,0,1,0,0,0,0,0,0,0,0,0,0)};
    tv[10] = '{1'b0, mk(1,0,0,0,0,1,1,1,1,0,0,0,0,0,0)};
    tv[11] = '{1'b0, mk(1,0,0,0,0,1,1,1,1,1,0,0,0,0,0)};
    tv[12] = '{1'b0, mk(1,0,0,0,0,1,1,1,1,2,1,0,0,0,0)};
    tv[13] = '{1'b0, mk(1,0,0,0,0,0,0,0,0,0,1,1,0,0,0)};
    tv[14] = '{1'b0, mk(1,0,0,0,0,0,0,0,0,0,1,2,0,0,0)};
    tv[15] = '{1'b0, mk(1,0,0,0,0,0,0,0,1,0,0,0,1,0,0)};
    tv[16] = '{1'b0, mk(1,0,0,0,0,0,0,0,1,1,0,0,1,1,0)};
    tv[17] = '{1'b0, mk(1,0,0,0,0,0,0,0,1,2,0,0,1,2,1)};
    tv[18] = '{1'b0, mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0,0)};
    tv[19] = '{1'b0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0)};

    repeat (2) @(posedge clk_in);
    #1;
    act_valid_in = 1'b1;
    #1;
    chk("reset_outputs", 64'(snap()), 64'(0));
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Two-pass layer, cycle by cycle.
    for (int i = 0; i < 20; i++) begin
      start_in = tv[i].st;
      num_ich_in = CH_W'(2);
      num_pos_in = POS_W'(3);
      act_valid_in = 1'b1;
      out_ready_in = 1'b1;
      #1;
      chk($sformatf("two_pass_c%0d", i), 64'(snap()),
          64'(tv[i].exp));
      @(posedge clk_in); #1;
    end
    start_in = 1'b0;

    // Alternating activation bubbles.
    run_layer(1, 3, 1'b1, 0, -1);
    exp_wc = '{5, 7, 9};
    exp_wa = '{0, 1, 2};
    chk("bubble_wr_count", wr_cyc.size(), 3);
    for (int i = 0; i < 3 && i < wr_cyc.size(); i++) begin
      chk($sformatf("bubble_wr_cyc%0d", i), wr_cyc[i], exp_wc[i]);
      chk($sformatf("bubble_wr_adr%0d", i), wr_adr[i], exp_wa[i]);
    end
    chk("bubble_last_ready", last_ardy, 7);
    chk("bubble_done", done_cyc, 13);

    // Readout backpressure at position 1.
    run_layer(1, 3, 1'b0, 4, -1);
    exp_wc = '{8, 13, 14};
    chk("stall_rd_count", rd_cyc.size(), 3);
    for (int i = 0; i < 3 && i < rd_cyc.size(); i++) begin
      chk($sformatf("stall_rd_cyc%0d", i), rd_cyc[i], exp_wc[i]);
      chk($sformatf("stall_rd_pos%0d", i), rd_pos[i], i);
    end
    chk("stall_valid_hold", stall_vld_n, 5);
    chk("stall_done", done_cyc, 15);

    // Zero position count.
    run_layer(2, 0, 1'b0, 0, -1);
    chk("zero_done", done_cyc, 1);
    chk("zero_busy_cycles", busy_n, 1);
    chk("zero_strobes", strobe_n, 0);

    // Reset during pass-0 drain, then a clean layer.
    start_in = 1'b1;
    num_ich_in = CH_W'(2);
    num_pos_in = POS_W'(3);
    act_valid_in = 1'b1;
    out_ready_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    chk("pre_rst_drain_wr", acc_wr_en_out, 1);
    chk("pre_rst_not_ready", act_ready_out, 0);
    #2 rst_in = 1'b1;
    #1;
    chk("async_rst_outputs", 64'(snap()), 64'(0));
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    rst_done_n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (done_out || busy_out) rst_done_n++;
      @(posedge clk_in); #1;
    end
    chk("rst_no_done", rst_done_n, 0);
    run_layer(2, 3, 1'b0, 0, -1);
    chk("post_rst_done", done_cyc, 18);
    chk("post_rst_wr_count", wr_cyc.size(), 6);
    if (wr_cyc.size() == 6) begin
      chk("post_rst_wr_last_cyc", wr_cyc[5], 14);
      chk("post_rst_wr_last_adr", wr_adr[5], 2);
    end

    // Start pulsed mid-stream with other counts is ignored.
    run_layer(1, 3, 1'b0, 0, 4);
    chk("busy_start_done", done_cyc, 11);
    chk("busy_start_rd_count", rd_cyc.size(), 3);
    chk("busy_start_wr_count", wr_cyc.size(), 3);
    if (rd_pos.size() == 3)
      chk("busy_start_last_pos", rd_pos[2], 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
